// File: rtl/bsg_encode_serial.sv
// Serializing binary encoder: streams the index of each set bit of an accepted
// vector, one per handshake, in lsb-first or msb-first priority order.
module bsg_encode_serial #(
  parameter int width_p     = 16,
  parameter bit lsb_first_p = 1'b1,
  localparam int lg_width_lp = $clog2(width_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [lg_width_lp-1:0] addr_o,
  output logic                   last_o,
  input  logic                   yumi_i
);

  logic [width_p-1:0] pending_r;
  logic [width_p-1:0] clr_mask;
  logic               found;
  int                 idx;

  // Priority search; the first hit in scan order wins.
  always_comb begin
    addr_o = '0;
    found  = 1'b0;
    idx    = 0;
    for (int i = 0; i < width_p; i++) begin
      idx = lsb_first_p ? i : (width_p - 1 - i);
      if (!found && pending_r[idx]) begin
        addr_o = lg_width_lp'(idx);
        found  = 1'b1;
      end
    end
  end

  assign v_o      = |pending_r;
  assign last_o   = v_o && ((pending_r & (pending_r - 1'b1)) == '0);
  // Taking the final index frees the slot in the same cycle: no bubble.
  assign ready_o  = reset_n_i && (!v_o || (last_o && yumi_i));
  assign clr_mask = {{(width_p-1){1'b0}}, 1'b1} << addr_o;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pending_r <= '0;
    end else if (v_i && ready_o) begin
      pending_r <= data_i;
    end else if (v_o && yumi_i) begin
      pending_r <= pending_r & ~clr_mask;
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    yumi_i |-> v_o);

endmodule

// File: doc/bsg_encode_serial.md
# bsg_encode_serial

Serializing binary encoder: the inverse of a one-hot/shift decoder. Accepts a `width_p`-bit bit-vector and emits, one per handshake, the binary index of each set bit, in priority order. Each emitted bit is cleared as it is consumed. Used wherever a decoded mask (grant, valid, dirty or pending vector) must be turned back into a stream of indices for a downstream unit that takes one address per cycle.

## Interface
- `width_p`, 16: input vector width; must be ≥2.
- `lsb_first_p`, 1: 1 = emit the lowest set index first; 0 = emit the highest set index first.
- `lg_width_lp`, $clog2(width_p): local; width of the index.

Ports:
- `clk_i` in 1: single clock, all state on the rising edge.
- `reset_n_i` in 1: reset, asynchronous, active-low.
- `v_i` in 1: input vector valid.
- `data_i` in `width_p`: bit-vector to encode.
- `ready_o` out 1: block can accept `data_i` this cycle.
- `v_o` out 1: `addr_o` valid.
- `addr_o` out `lg_width_lp`: binary index of the current priority set bit.
- `last_o` out 1: the current index is the final one of this vector.
- `yumi_i` in 1: consumer takes `addr_o` this cycle; only legal when `v_o` = 1.

## Operation
- State is a `width_p`-bit `pending_r` register. There are two implicit states: EMPTY (`pending_r` = 0) and ACTIVE (`pending_r` ≠ 0).
- Outputs are combinational from `pending_r`:
  - `v_o` = |`pending_r`.
  - `addr_o` = index of the lowest set bit if `lsb_first_p`=1, else the highest set bit. `addr_o` = 0 when `v_o` = 0.
  - `last_o` = `v_o` & (`pending_r` has exactly one bit set).
- `ready_o` = EMPTY | (`v_o` & `last_o` & `yumi_i`). This gives back-to-back vectors with no bubble. `ready_o` depends combinationally on `yumi_i`; there is no path from `v_i` to `ready_o`.
- Accept: `v_i` & `ready_o`. Then `pending_r` <= `data_i`. The accept overrides the clear of the last bit on the same edge.
- Consume: `v_o` & `yumi_i` without an accept. Then `pending_r` <= `pending_r` with the `addr_o` bit cleared.
- Zero vector: `data_i` = 0 is accepted and dropped. No output is produced and the block stays EMPTY.
- `v_i` while not ready: ignored. The upstream must hold the vector; the block never latches it.
- `yumi_i` while `v_o` = 0: ignored. The state is unchanged. The assertion build flags this as a protocol error.
- Reset (`reset_n_i` = 0, at any time including mid-vector): `pending_r` clears to 0 immediately. Any remaining indices are discarded.
  - Outputs during and after reset: `v_o` = 0, `addr_o` = 0, `last_o` = 0.
  - `ready_o` is forced to 0 while `reset_n_i` is low and returns to 1 on the first cycle after deassertion.

## Timing
- Latency: a vector accepted at edge N drives `v_o` = 1 with its first index during cycle N+1.
- Throughput: one index per cycle while `yumi_i` is held at 1. A vector with k set bits occupies exactly k cycles.
  - Vectors with k ≥ 1 stream back-to-back with zero idle cycles.
  - An all-zero vector costs one accept cycle.
- `addr_o`, `v_o` and `last_o` are stable while `yumi_i` = 0. Only a consume, an accept or a reset changes them.
- Reset is asynchronous on assertion. Deassertion is expected to be synchronized upstream to `clk_i`.

## Test plan
- Reset and idle:
  - Assert `reset_n_i` = 0 mid-cycle → `v_o` = 0, `addr_o` = 0, `last_o` = 0, `ready_o` = 0 immediately.
  - Release → `ready_o` = 1 on the next cycle, with no `v_o`.
- Basic encode, `lsb_first_p` = 1:
  - Accept `data_i` = 16'h8421 with `yumi_i` held 1 → `addr_o` = 0, 5, 10, 15 on four consecutive cycles.
  - `last_o` = 1 only with `addr_o` = 15.
  - `ready_o` = 1 on that final cycle.
- Back-to-back and zero vector:
  - Accept 16'h0003, then 16'h0000 on the last-consume cycle, then 16'h8000 → output stream 0, 1 (`last_o`), 15 (`last_o`).
  - The zero vector produces no output.
- Backpressure and stability:
  - Accept 16'h0110 and hold `yumi_i` = 0 for 5 cycles → `addr_o` stays 4, `v_o` = 1, `ready_o` = 0.
  - `v_i` = 1 with 16'hFFFF during the stall is not accepted.
  - Release `yumi_i` → outputs 4, then 8.
- Reverse order, `lsb_first_p` = 0:
  - Accept 16'hFFFF → `addr_o` = 15 down to 0 over 16 cycles.
  - `last_o` = 1 only with `addr_o` = 0.
- Reset mid-vector:
  - Accept 16'h00F0, consume 4, then pulse `reset_n_i` low → `v_o` drops immediately.
  - After release, the block is EMPTY. Indices 5, 6 and 7 are never emitted.
